// File: rtl/body_regfile_if.sv
// Host-side Avalon-MM slave bundle for the body-state register file.
// The host CPU is the master; body_regfile is the slave.
interface body_regfile_if #(
    parameter int AW = 7
);
    logic          AVL_CS;
    logic          AVL_READ;
    logic          AVL_WRITE;
    logic [AW-1:0] AVL_ADDR;
    logic [3:0]    AVL_BYTE_EN;
    logic [31:0]   AVL_WRITEDATA;
    logic [31:0]   AVL_READDATA;

    modport master (
        output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
        input  AVL_READDATA
    );

    modport slave (
        input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
        output AVL_READDATA
    );
endinterface

// File: rtl/body_regfile.sv
// Body-state register file: host load/readback over Avalon-MM, three-port timestep
// FSM write-back, whole-array export, and the FSM_START/FSM_DONE run handshake.
module body_regfile #(
    parameter int NWORDS    = 113,
    parameter int AW        = 7,
    parameter int CTRL_ADDR = 113
) (
    input  logic        CLK,
    input  logic        RESET,
    body_regfile_if.slave avl,
    output logic        FSM_START,
    input  logic        FSM_DONE,
    input  logic        FSM_we,
    input  logic [31:0] ADDR1,
    input  logic [31:0] ADDR2,
    input  logic [31:0] ADDR3,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] data3,
    output logic [31:0] datafile [NWORDS]
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrlState_t;

    ctrlState_t  state, stateNext;
    logic        doneFlag, errFlag;
    logic [31:0] readData;

    // Host access decode
    logic        hostRd, hostWr;
    logic        ctrlHit, wordHit;
    logic        ctrlWr, startReq;
    logic        dataWr, dataWrOk, dataWrBad;
    logic [31:0] beMask;
    logic [31:0] status;
    logic [31:0] rdMux;

    assign hostRd    = avl.AVL_CS & avl.AVL_READ;
    assign hostWr    = avl.AVL_CS & avl.AVL_WRITE;
    assign ctrlHit   = (avl.AVL_ADDR == AW'(CTRL_ADDR));
    assign wordHit   = (32'(avl.AVL_ADDR) < 32'(NWORDS));
    assign ctrlWr    = hostWr & ctrlHit;
    assign startReq  = ctrlWr & avl.AVL_WRITEDATA[0];
    assign dataWr    = hostWr & wordHit;
    assign dataWrOk  = dataWr & (state == IDLE);
    assign dataWrBad = dataWr & (state != IDLE);

    assign beMask = {{8{avl.AVL_BYTE_EN[3]}}, {8{avl.AVL_BYTE_EN[2]}},
                     {8{avl.AVL_BYTE_EN[1]}}, {8{avl.AVL_BYTE_EN[0]}}};

    // Control FSM: state register
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments for all flops so every register samples
        // pre-edge values regardless of process evaluation order.
        if (RESET) state <= IDLE;
        else       state <= stateNext;
    end

    // Control FSM: next state and START decode
    always_comb begin
        // NOTE: every output of this block is given a default first so no path
        // leaves a variable unassigned and infers a latch.
        stateNext = state;
        FSM_START = 1'b0;
        unique case (state)
            IDLE: begin
                if (startReq) stateNext = RUN;
            end
            RUN: begin
                FSM_START = 1'b1;
                if (FSM_DONE) stateNext = DRAIN;
            end
            DRAIN: begin
                if (!FSM_DONE) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Sticky status bits; a set event in the same cycle as a clear wins.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            doneFlag <= 1'b0;
            errFlag  <= 1'b0;
        end else begin
            if (ctrlWr && avl.AVL_WRITEDATA[2])      doneFlag <= 1'b0;
            if (state == IDLE && startReq)           doneFlag <= 1'b0;
            if (state == DRAIN && !FSM_DONE)         doneFlag <= 1'b1;
            if (ctrlWr && avl.AVL_WRITEDATA[3])      errFlag  <= 1'b0;
            if (dataWrBad)                           errFlag  <= 1'b1;
        end
    end

    assign status = {28'b0, errFlag, doneFlag, (state != IDLE), FSM_START};

    // Read mux sees pre-edge contents, so a same-cycle write returns the old value.
    always_comb begin
        rdMux = 32'b0;
        if (wordHit)      rdMux = datafile[avl.AVL_ADDR];
        else if (ctrlHit) rdMux = status;
    end

    always_ff @(posedge CLK) begin
        if (RESET)       readData <= 32'b0;
        else if (hostRd) readData <= rdMux;
    end

    assign avl.AVL_READDATA = readData;

    // One flop word per address; later assignments in the merge take priority.
    for (genvar g = 0; g < NWORDS; g++) begin : gWord
        logic [31:0] word;
        logic [31:0] wordNext;
        logic        wordWe;

        always_comb begin
            wordNext = word;
            wordWe   = 1'b0;
            if (dataWrOk && avl.AVL_ADDR == AW'(g)) begin
                wordNext = (word & ~beMask) | (avl.AVL_WRITEDATA & beMask);
                wordWe   = 1'b1;
            end
            if (FSM_we && ADDR1 == 32'(g)) begin
                wordNext = data1;
                wordWe   = 1'b1;
            end
            if (FSM_we && ADDR2 == 32'(g)) begin
                wordNext = data2;
                wordWe   = 1'b1;
            end
            if (FSM_we && ADDR3 == 32'(g)) begin
                wordNext = data3;
                wordWe   = 1'b1;
            end
        end

        always_ff @(posedge CLK) begin
            // NOTE: the array is exported live to the timestep FSM, so it is
            // built from resettable flops rather than an un-reset RAM.
            if (RESET)       word <= 32'b0;
            else if (wordWe) word <= wordNext;
        end

        assign datafile[g] = word;
    end

endmodule

// File: tb/tb_body_regfile.sv
// Self-checking bench for body_regfile: directed scenarios plus randomized traffic,
// with host readback checked through a queue-based scoreboard against a behavioural model.
module tb_body_regfile;

    localparam int NWORDS    = 113;
    localparam int AW        = 7;
    localparam int CTRL_ADDR = 113;
    localparam int PH_IDLE   = 0;
    localparam int PH_RUN    = 1;
    localparam int PH_DRAIN  = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        FSM_START;
    logic        FSM_DONE;
    logic        FSM_we;
    logic [31:0] ADDR1, ADDR2, ADDR3;
    logic [31:0] data1, data2, data3;
    logic [31:0] datafile [NWORDS];

    always #5 CLK = ~CLK;

    body_regfile_if #(.AW(AW)) bus ();

    body_regfile #(
        .NWORDS(NWORDS),
        .AW(AW),
        .CTRL_ADDR(CTRL_ADDR)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .avl(bus),
        .FSM_START(FSM_START),
        .FSM_DONE(FSM_DONE),
        .FSM_we(FSM_we),
        .ADDR1(ADDR1),
        .ADDR2(ADDR2),
        .ADDR3(ADDR3),
        .data1(data1),
        .data2(data2),
        .data3(data3),
        .datafile(datafile)
    );

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;

    // Reference model state
    logic [31:0] mWords [NWORDS];
    int          mPhase = PH_IDLE;
    bit          mDone  = 1'b0;
    bit          mErr   = 1'b0;
    logic [31:0] expQ [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [AW-1:0] a);
        if (int'(a) < NWORDS) return mWords[a];
        if (int'(a) == CTRL_ADDR)
            return {28'b0, mErr, mDone, (mPhase != PH_IDLE), (mPhase == PH_RUN)};
        return 32'b0;
    endfunction

    task automatic idleInputs();
        bus.AVL_CS        = 1'b0;
        bus.AVL_READ      = 1'b0;
        bus.AVL_WRITE     = 1'b0;
        bus.AVL_ADDR      = '0;
        bus.AVL_BYTE_EN   = 4'b0;
        bus.AVL_WRITEDATA = 32'b0;
        FSM_we = 1'b0;
        ADDR1 = 32'b0; ADDR2 = 32'b0; ADDR3 = 32'b0;
        data1 = 32'b0; data2 = 32'b0; data3 = 32'b0;
    endtask

    // Apply one clock edge: predict from the driven inputs, clock, then compare outputs.
    task automatic cycle();
        logic [31:0] nWords [NWORDS];
        logic [31:0] fa [3];
        logic [31:0] fd [3];
        int  nPhase;
        bit  nDone, nErr;
        int  bad, idx;
        nWords = mWords;
        nPhase = mPhase;
        nDone  = mDone;
        nErr   = mErr;
        if (RESET) begin
            foreach (nWords[i]) nWords[i] = 32'b0;
            nPhase = PH_IDLE;
            nDone  = 1'b0;
            nErr   = 1'b0;
        end else begin
            if (bus.AVL_CS && bus.AVL_READ) expQ.push_back(modelRead(bus.AVL_ADDR));
            if (bus.AVL_CS && bus.AVL_WRITE) begin
                if (int'(bus.AVL_ADDR) == CTRL_ADDR) begin
                    if (bus.AVL_WRITEDATA[2]) nDone = 1'b0;
                    if (bus.AVL_WRITEDATA[3]) nErr  = 1'b0;
                    if (bus.AVL_WRITEDATA[0] && mPhase == PH_IDLE) begin
                        nPhase = PH_RUN;
                        nDone  = 1'b0;
                    end
                end else if (int'(bus.AVL_ADDR) < NWORDS) begin
                    if (mPhase == PH_IDLE) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.AVL_BYTE_EN[b])
                                nWords[bus.AVL_ADDR][8*b +: 8] = bus.AVL_WRITEDATA[8*b +: 8];
                    end else begin
                        nErr = 1'b1;
                    end
                end
            end
            if (mPhase == PH_RUN && FSM_DONE) nPhase = PH_DRAIN;
            if (mPhase == PH_DRAIN && !FSM_DONE) begin
                nPhase = PH_IDLE;
                nDone  = 1'b1;
            end
            fa[0] = ADDR1; fa[1] = ADDR2; fa[2] = ADDR3;
            fd[0] = data1; fd[1] = data2; fd[2] = data3;
            if (FSM_we)
                for (int p = 0; p < 3; p++)
                    if (fa[p] < 32'(NWORDS)) nWords[fa[p][6:0]] = fd[p];
        end
        @(posedge CLK);
        #1;
        cyc++;
        mWords = nWords;
        mPhase = nPhase;
        mDone  = nDone;
        mErr   = nErr;
        check("fsm_start", {31'b0, FSM_START}, {31'b0, (mPhase == PH_RUN)});
        bad = -1;
        for (int i = 0; i < NWORDS; i++)
            if (bad < 0 && datafile[i] !== mWords[i]) bad = i;
        idx = (bad >= 0) ? bad : (cyc % NWORDS);
        check($sformatf("datafile[%0d]", idx), datafile[idx], mWords[idx]);
    endtask

    task automatic hostWrite(input int a, input logic [31:0] d, input logic [3:0] be);
        idleInputs();
        bus.AVL_CS = 1'b1; bus.AVL_WRITE = 1'b1;
        bus.AVL_ADDR = AW'(a); bus.AVL_WRITEDATA = d; bus.AVL_BYTE_EN = be;
        cycle();
        idleInputs();
    endtask

    task automatic hostRead(input int a);
        idleInputs();
        bus.AVL_CS = 1'b1; bus.AVL_READ = 1'b1; bus.AVL_ADDR = AW'(a);
        cycle();
        idleInputs();
    endtask

    task automatic fsmWrite(input logic [31:0] a1, d1, a2, d2, a3, d3);
        idleInputs();
        FSM_we = 1'b1;
        ADDR1 = a1; data1 = d1; ADDR2 = a2; data2 = d2; ADDR3 = a3; data3 = d3;
        cycle();
        idleInputs();
    endtask

    // Monitor: READDATA must take the queued value one edge after a read, else hold.
    initial begin : monitor
        logic [31:0] held;
        bit fire, rst;
        held = 32'b0;
        forever begin
            @(posedge CLK);
            fire = bus.AVL_CS && bus.AVL_READ && !RESET;
            rst  = RESET;
            @(negedge CLK);
            if (rst) begin
                held = 32'b0;
            end else if (fire) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL scoreboard: read completed with no expected entry (t=%0t)", $time);
                end else begin
                    held = expQ.pop_front();
                end
            end
            check("readdata", bus.AVL_READDATA, held);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int r;
        foreach (mWords[i]) mWords[i] = 32'b0;
        RESET = 1'b1;
        FSM_DONE = 1'b0;
        idleInputs();
        cycle();
        cycle();
        RESET = 1'b0;

        // Reset state and read latency
        check("reset_start", {31'b0, FSM_START}, 32'd0);
        hostRead(0);
        hostRead(56);
        hostRead(112);
        hostRead(CTRL_ADDR);

        // Byte-enable merge
        hostWrite(22, 32'h3F80_0000, 4'b0011);
        hostWrite(22, 32'h4000_0000, 4'b1100);
        hostRead(22);
        check("t2_word22", datafile[22], 32'h4000_0000);

        // Run handshake, dropped write, ERR
        hostWrite(CTRL_ADDR, 32'h1, 4'hF);
        check("t3_start", {31'b0, FSM_START}, 32'd1);
        hostWrite(5, 32'hDEAD_BEEF, 4'hF);
        hostRead(CTRL_ADDR);
        FSM_DONE = 1'b1;
        cycle();
        check("t3_start_drop", {31'b0, FSM_START}, 32'd0);
        FSM_DONE = 1'b0;
        cycle();
        hostRead(CTRL_ADDR);
        hostRead(5);
        hostWrite(CTRL_ADDR, 32'hC, 4'hF);
        hostRead(CTRL_ADDR);

        // FSM port priority and out-of-range ports
        fsmWrite(32'd53, 32'd1, 32'd53, 32'd2, 32'd53, 32'd3);
        check("t4_word53", datafile[53], 32'd3);
        fsmWrite(32'd52, 32'h11, 32'd200, 32'h22, 32'd52, 32'h33);
        check("t4_word52", datafile[52], 32'h33);
        fsmWrite(32'h8000_0035, 32'h77, 32'd113, 32'h88, 32'hFFFF_FFFF, 32'h99);
        hostRead(53);

        // FSM beats host on the same word; same-cycle read returns old value
        idleInputs();
        bus.AVL_CS = 1'b1; bus.AVL_WRITE = 1'b1; bus.AVL_READ = 1'b1;
        bus.AVL_ADDR = AW'(63); bus.AVL_WRITEDATA = 32'h0000_5555; bus.AVL_BYTE_EN = 4'hF;
        FSM_we = 1'b1; ADDR1 = 32'd63; data1 = 32'hAAAA_0000;
        ADDR2 = 32'd300; ADDR3 = 32'd301;
        cycle();
        idleInputs();
        check("t5_word63", datafile[63], 32'hAAAA_0000);
        hostRead(63);

        // Reset during RUN
        hostWrite(CTRL_ADDR, 32'h1, 4'hF);
        fsmWrite(32'd0, 32'h1234, 32'd112, 32'h5678, 32'd7, 32'h9ABC);
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        check("t6_start", {31'b0, FSM_START}, 32'd0);
        check("t6_word112", datafile[112], 32'd0);
        hostRead(CTRL_ADDR);
        hostWrite(CTRL_ADDR, 32'h1, 4'hF);
        check("t6_restart", {31'b0, FSM_START}, 32'd1);
        FSM_DONE = 1'b1;
        cycle();
        FSM_DONE = 1'b0;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idleInputs();
            r = $urandom_range(0, 99);
            if (r < 60) begin
                bus.AVL_CS    = 1'b1;
                bus.AVL_READ  = $urandom_range(0, 1) == 1;
                bus.AVL_WRITE = $urandom_range(0, 2) == 0;
                case ($urandom_range(0, 5))
                    0:       bus.AVL_ADDR = AW'(CTRL_ADDR);
                    1:       bus.AVL_ADDR = AW'(NWORDS - 1);
                    2:       bus.AVL_ADDR = AW'($urandom_range(114, 127));
                    default: bus.AVL_ADDR = AW'($urandom_range(0, NWORDS - 1));
                endcase
                bus.AVL_BYTE_EN   = 4'($urandom_range(0, 15));
                bus.AVL_WRITEDATA = $urandom();
                if (int'(bus.AVL_ADDR) == CTRL_ADDR && $urandom_range(0, 1) == 1)
                    bus.AVL_WRITEDATA[0] = 1'b1;
            end
            if ($urandom_range(0, 9) < 3) begin
                FSM_we = 1'b1;
                ADDR1 = ($urandom_range(0, 3) == 0) ? {1'b1, 31'($urandom_range(0, 200))}
                                                    : 32'($urandom_range(0, 120));
                ADDR2 = 32'($urandom_range(0, 120));
                ADDR3 = ($urandom_range(0, 3) == 0) ? ADDR2 : 32'($urandom_range(100, 130));
                data1 = $urandom(); data2 = $urandom(); data3 = $urandom();
            end
            if ($urandom_range(0, 9) == 0) FSM_DONE = ~FSM_DONE;
            RESET = ($urandom_range(0, 199) == 0);
            cycle();
        end
        RESET = 1'b0;
        idleInputs();
        cycle();
        cycle();
        check("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
